// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer: REQ -> WAIT -> EXEC per instruction.
// Optional `PC_ALIGN_CHECK_EN adds o_pc_misalign and a halt state on misaligned next PC.
module pc_fetch_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [1:0]      i_pc_src,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_csr_pc,
   input  logic            i_commit,
   output logic            o_ifu_req_valid,
   input  logic            i_ifu_req_ready,
   output logic [XLEN-1:0] o_ifu_addr,
   input  logic            i_ifu_rsp_valid,
   input  logic [XLEN-1:0] i_ifu_rsp_data,
`ifdef PC_ALIGN_CHECK_EN
   output logic            o_pc_misalign,
`endif
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_inst,
   output logic            o_inst_valid
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_EXEC = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inst;
   logic            r_inst_valid;
   logic [XLEN-1:0] w_next_pc;
   logic [XLEN-1:0] w_jalr_sum;
   logic            w_req_valid;
   logic            w_load_inst;
   logic            w_take_commit;
`ifdef PC_ALIGN_CHECK_EN
   logic            r_pc_misalign;
   logic            w_halt;
`endif

   assign w_jalr_sum = i_rs1_data + i_imm;

   always_comb begin
      case (i_pc_src)
         2'b00:   w_next_pc = r_pc + XLEN'(4);
         2'b01:   w_next_pc = r_pc + i_imm;
         2'b10:   w_next_pc = w_jalr_sum & ~XLEN'(1);
         default: w_next_pc = i_csr_pc;
      endcase
   end

   always_comb begin
      w_state_next  = r_state;
      w_req_valid   = 1'b0;
      w_load_inst   = 1'b0;
      w_take_commit = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      w_halt        = 1'b0;
`endif
      case (r_state)
         S_REQ: begin
            w_req_valid = 1'b1;
            if (i_ifu_req_ready) w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (i_ifu_rsp_valid) begin
               w_load_inst  = 1'b1;
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (i_commit) begin
`ifdef PC_ALIGN_CHECK_EN
               if (w_next_pc[1:0] != 2'b00) begin
                  w_halt       = 1'b1;
                  w_state_next = S_HALT;
               end else begin
                  w_take_commit = 1'b1;
                  w_state_next  = S_REQ;
               end
`else
               w_take_commit = 1'b1;
               w_state_next  = S_REQ;
`endif
            end
         end
         default: w_state_next = r_state;  // S_HALT: only reset leaves it
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_REQ;
         r_pc         <= RESET_PC;
         r_inst       <= '0;
         r_inst_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         r_pc_misalign <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         if (w_load_inst) begin
            r_inst       <= i_ifu_rsp_data;
            r_inst_valid <= 1'b1;
         end
         if (w_take_commit) begin
            r_pc         <= w_next_pc;
            r_inst_valid <= 1'b0;
         end
`ifdef PC_ALIGN_CHECK_EN
         if (w_halt) begin
            r_pc_misalign <= 1'b1;
            r_inst_valid  <= 1'b0;
         end
`endif
      end
   end

   // Gated by reset so no request leaks out while the memory side is also in reset.
   assign o_ifu_req_valid = w_req_valid & i_rst_n;
   assign o_ifu_addr      = r_pc;
   assign o_pc            = r_pc;
   assign o_inst          = r_inst;
   assign o_inst_valid    = r_inst_valid;
`ifdef PC_ALIGN_CHECK_EN
   assign o_pc_misalign   = r_pc_misalign;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
PC register and instruction-fetch sequencer for the scpu core. It sits directly downstream of the next-PC selector and consumes its 2-bit pc_src.
- Holds the architectural PC.
- Issues one fetch per instruction over a valid/ready request plus response-valid interface to instruction memory.
- Presents the fetched instruction to decode.
- On the commit pulse, computes the next PC from pc_src.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
XLEN, 32, width of PC, operands and instruction word.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
pc_src  input  2  next-PC select: 00 pc+4, 01 pc+imm, 10 rs1+imm, 11 csr_pc
imm  input  XLEN  sign-extended immediate of current instruction
rs1_data  input  XLEN  rs1 value (jalr base)
csr_pc  input  XLEN  mepc/mtvec target from CSR unit
commit  input  1  current instruction finished; pc_src/imm/rs1_data/csr_pc valid this cycle
ifu_req_valid  output  1  fetch request valid
ifu_req_ready  input  1  memory accepts request
ifu_addr  output  XLEN  fetch address, equals pc
ifu_rsp_valid  input  1  response data valid
ifu_rsp_data  input  XLEN  fetched instruction
pc  output  XLEN  current PC
inst  output  XLEN  latched instruction
inst_valid  output  1  inst holds the instruction at pc

Behaviour:
- Reset is synchronous: when rst_n=0 at an edge, the following are loaded:
  - pc=RESET_PC
  - state=S_REQ
  - inst=0
  - inst_valid=0
- ifu_req_valid is combinational from state and is therefore 0 while rst_n=0 (reset-state gating).
- State S_REQ:
  - ifu_req_valid=1, ifu_addr=pc.
  - Handshake occurs when valid & ready; then go to S_WAIT.
  - ifu_addr is held stable while valid & !ready.
- State S_WAIT:
  - ifu_req_valid=0.
  - On ifu_rsp_valid=1: inst<=ifu_rsp_data, inst_valid<=1, go to S_EXEC.
  - The response arrives no earlier than the cycle after the handshake.
- State S_EXEC:
  - inst_valid=1; inst and pc are stable.
  - On commit=1: pc<=next_pc, inst_valid<=0, go to S_REQ.
  - The new request is visible the cycle after commit.
- next_pc:
  - 00: pc+4
  - 01: pc+imm
  - 10: (rs1_data+imm) & ~1
  - 11: csr_pc
  - All sums are modulo 2^XLEN; wrap-around is silent, e.g. 32'hFFFF_FFFC+4 = 0.
- commit outside S_EXEC is ignored.
- ifu_rsp_valid outside S_WAIT is ignored.
- Minimum cycles per instruction with a zero-wait memory: REQ(1) + WAIT(1) + EXEC(1) = 3.
- Reset mid-fetch abandons any outstanding request. The instruction memory is reset by the same rst_n, so no stale response follows.
- Simultaneous commit and rst_n=0: reset wins.

Optional Feature:
PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output port pc_misalign (1 bit, reset 0) and state S_HALT.
  - In S_EXEC with commit=1 and next_pc[1:0]!=0: pc is not updated, pc_misalign<=1, go to S_HALT.
  - S_HALT issues no requests, keeps inst_valid=0, and is left only by reset.
- Undefined: no port, no check; the unaligned next_pc is fetched as-is.

Test Plan:
- Reset then ready=1, response one cycle later with 32'h0000_0013 → ifu_addr=32'h8000_0000 on the first request; inst=32'h13 with inst_valid=1 two cycles after the handshake.
- commit with pc_src=00, then pc_src=01 with imm=-8 → pc goes 80000000 → 80000004 → 7FFFFFFC.
- pc_src=10, rs1=32'h8000_1003, imm=2 → pc=32'h8000_1004 (bit 0 cleared); pc_src=11, csr_pc=32'h8000_0100 → pc=32'h8000_0100.
- ifu_req_ready held 0 for 5 cycles → ifu_req_valid=1 and ifu_addr constant throughout; a spurious ifu_rsp_valid during S_REQ leaves inst unchanged.
- rst_n=0 asserted in S_WAIT and in S_EXEC together with commit → next cycle pc=RESET_PC, inst_valid=0, state S_REQ.
- With PC_ALIGN_CHECK_EN, pc_src=01, imm=2 → pc_misalign=1, pc unchanged, ifu_req_valid stays 0 until reset.
